// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign handled by operating on magnitudes and correcting at the end.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             sign_q, sign_r, b_zero;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] dvd;   // dividend shifts out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sh, diff;
  logic             ge;

  // Magnitude of 0x80000000 wraps to itself, which is exactly what the
  // overflow case needs once read as unsigned.
  assign abs_a = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign abs_b = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

  assign sh   = {rem, dvd[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  assign ge   = (sh >= {1'b0, dvs});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      b_zero      <= 1'b0;
      a_orig      <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            sign_r <= is_signed & A[WIDTH-1];
            b_zero <= (B == '0);
            a_orig <= A;
            dvd    <= abs_a;
            dvs    <= abs_b;
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          rem <= ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIN;
        end
        FIN: begin
          // Divide-by-zero runs the full iteration count so latency stays fixed.
          quotient    <= b_zero ? '1     : (sign_q ? (~dvd + 1'b1) : dvd);
          remainder   <= b_zero ? a_orig : (sign_r ? (~rem + 1'b1) : rem);
          div_by_zero <= b_zero;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed checks of div_unit: arithmetic cases, latency, handshake, reset abort.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] quotient, remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .A(A), .B(B), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a request just after an edge; returns after the accepting edge (+1).
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    is_signed = s; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done; optionally pokes a second start at cycle 10.
  task automatic wait_done(input bit poke, output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (lat < 60) begin
      if (poke && lat == 9) begin
        is_signed = 1'b0; A = 32'd9; B = 32'd3; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int lat, bcnt;
    issue(s, a, b);
    wait_done(1'b0, lat, bcnt);
    chk({tag, ".lat"}, lat, 33);
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    chk({tag, ".busy_n"}, bcnt, 33);
    @(posedge clk); #1;
    chk({tag, ".done_w"}, {31'd0, done}, 32'd0);
    chk({tag, ".q_hold"}, quotient, eq);
  endtask

  initial begin
    int lat, bcnt;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.q", quotient, 32'd0);
    chk("rst.r", remainder, 32'd0);
    chk("rst.dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run("divu100_7", 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run("div-7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
    run("div7_-2",   1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0);
    run("div_ovf",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
    run("divu_ovf",  1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0);
    run("div_z",     1'b1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1);
    run("divu_z",    1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1);
    run("div_nn",    1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0);

    // Second start during the run is ignored; then restart in the done cycle.
    issue(1'b0, 32'd50, 32'd5);
    wait_done(1'b1, lat, bcnt);
    chk("ign.lat", lat, 33);
    chk("ign.q", quotient, 32'd10);
    chk("ign.r", remainder, 32'd0);
    issue(1'b0, 32'd81, 32'd9);
    chk("b2b.done_w", {31'd0, done}, 32'd0);
    chk("b2b.busy", {31'd0, busy}, 32'd1);
    wait_done(1'b0, lat, bcnt);
    chk("b2b.lat", lat + 1, 34);
    chk("b2b.q", quotient, 32'd9);
    @(posedge clk); #1;

    // Reset mid-operation clears outputs immediately, no stray done afterwards.
    issue(1'b0, 32'd123456, 32'd7);
    repeat (14) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.q", quotient, 32'd0);
    chk("abort.r", remainder, 32'd0);
    chk("abort.dz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      chk("abort.quiet", seen, 0);
    end
    run("post_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
